// File: rtl/mips.sv
// 5-stage pipelined MIPS-subset core with unified word-addressed memory.
// Forwarding, load-use stall, EX-resolved branches and HLT drain.
package mips_pkg;
  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_SLT   = 6'b000011,
    OP_MUL   = 6'b000100,
    OP_OR    = 6'b000101,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_LW    = 6'b001101,
    OP_SW    = 6'b001110,
    OP_BNEQZ = 6'b001111,
    OP_BEQZ  = 6'b010000,
    OP_HLT   = 6'b111111
  } op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    op_e         op;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        wr;
    logic        ld;
    logic        st;
    logic        br;
    logic        hlt;
    logic        ri;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wr;
    logic        ld;
    logic        st;
    logic        hlt;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wr;
    logic        hlt;
  } mem_wb_t;
endpackage

module mips
  import mips_pkg::*;
#(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic clock,
  input  logic reset_n,
  output logic halted
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        taken_branch;

  if_id_t  if_id;
  id_ex_t  id_ex, id_nxt;
  ex_mem_t ex_mem, ex_nxt;
  mem_wb_t mem_wb, wb_nxt;

  logic [4:0]  rs, rt, rd;
  logic [31:0] ra, rb, imm;
  logic        d_rr, d_ri, d_ld, d_st, d_br, d_hlt;
  logic        wb_we, ld_use, hlt_pend, take;
  logic        fa_em, fa_mw, fb_em, fb_mw;
  logic [31:0] fa, fb, bsel, alu, target;

  assign rs  = if_id.ir[25:21];
  assign rt  = if_id.ir[20:16];
  assign rd  = if_id.ir[15:11];
  assign imm = {{16{if_id.ir[15]}}, if_id.ir[15:0]};

  assign wb_we = mem_wb.valid && mem_wb.wr
               && !halted && mem_wb.dst != 5'd0;

  // register file reads see the WB write of this same cycle
  always_comb begin
    ra = 32'd0;
    rb = 32'd0;
    if (rs != 5'd0)
      ra = (wb_we && mem_wb.dst == rs) ? mem_wb.res : Reg[rs];
    if (rt != 5'd0)
      rb = (wb_we && mem_wb.dst == rt) ? mem_wb.res : Reg[rt];
  end

  always_comb begin
    d_rr  = 1'b0;
    d_ri  = 1'b0;
    d_ld  = 1'b0;
    d_st  = 1'b0;
    d_br  = 1'b0;
    d_hlt = 1'b0;
    case (op_e'(if_id.ir[31:26]))
      OP_ADD, OP_SUB, OP_AND,
      OP_SLT, OP_MUL, OP_OR:     d_rr  = 1'b1;
      OP_ADDI, OP_SUBI, OP_SLTI: d_ri  = 1'b1;
      OP_LW:                     d_ld  = 1'b1;
      OP_SW:                     d_st  = 1'b1;
      OP_BNEQZ, OP_BEQZ:         d_br  = 1'b1;
      OP_HLT:                    d_hlt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    id_nxt       = '0;
    id_nxt.valid = 1'b1;
    id_nxt.op    = op_e'(if_id.ir[31:26]);
    id_nxt.pc    = if_id.pc;
    id_nxt.rs    = rs;
    id_nxt.rt    = rt;
    id_nxt.dst   = d_rr ? rd : rt;
    id_nxt.a     = ra;
    id_nxt.b     = rb;
    id_nxt.imm   = imm;
    id_nxt.wr    = d_rr | d_ri | d_ld;
    id_nxt.ld    = d_ld;
    id_nxt.st    = d_st;
    id_nxt.br    = d_br;
    id_nxt.hlt   = d_hlt;
    id_nxt.ri    = d_ri;
  end

  assign ld_use = if_id.valid && !d_hlt
               && id_ex.valid && id_ex.ld
               && id_ex.dst != 5'd0
               && (id_ex.dst == rs || id_ex.dst == rt);

  assign hlt_pend = (if_id.valid && d_hlt)
                 || (id_ex.valid && id_ex.hlt)
                 || (ex_mem.valid && ex_mem.hlt)
                 || (mem_wb.valid && mem_wb.hlt)
                 || halted;

  // EX/MEM holds only ALU results here; loads reach EX via MEM/WB
  assign fa_em = ex_mem.valid && ex_mem.wr && !ex_mem.ld
              && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rs;
  assign fa_mw = !fa_em && mem_wb.valid && mem_wb.wr
              && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rs;
  assign fb_em = ex_mem.valid && ex_mem.wr && !ex_mem.ld
              && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rt;
  assign fb_mw = !fb_em && mem_wb.valid && mem_wb.wr
              && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rt;

  always_comb begin
    unique case (1'b1)
      fa_em:   fa = ex_mem.alu;
      fa_mw:   fa = mem_wb.res;
      default: fa = id_ex.a;
    endcase
    unique case (1'b1)
      fb_em:   fb = ex_mem.alu;
      fb_mw:   fb = mem_wb.res;
      default: fb = id_ex.b;
    endcase
  end

  assign bsel = (id_ex.ri || id_ex.ld || id_ex.st) ? id_ex.imm : fb;

  always_comb begin
    case (id_ex.op)
      OP_ADD, OP_ADDI,
      OP_LW, OP_SW:     alu = fa + bsel;
      OP_SUB, OP_SUBI:  alu = fa - bsel;
      OP_AND:           alu = fa & bsel;
      OP_OR:            alu = fa | bsel;
      OP_SLT, OP_SLTI:  alu = {31'd0, $signed(fa) < $signed(bsel)};
      OP_MUL:           alu = fa * bsel;
      default:          alu = 32'd0;
    endcase
  end

  assign take   = id_ex.valid && id_ex.br
               && ((id_ex.op == OP_BEQZ) == (fa == 32'd0));
  assign target = id_ex.pc + 32'd1 + id_ex.imm;

  always_comb begin
    ex_nxt       = '0;
    ex_nxt.valid = id_ex.valid;
    ex_nxt.alu   = alu;
    ex_nxt.b     = fb;
    ex_nxt.dst   = id_ex.dst;
    ex_nxt.wr    = id_ex.wr;
    ex_nxt.ld    = id_ex.ld;
    ex_nxt.st    = id_ex.st;
    ex_nxt.hlt   = id_ex.hlt;
  end

  always_comb begin
    wb_nxt       = '0;
    wb_nxt.valid = ex_mem.valid;
    wb_nxt.res   = ex_mem.ld ? Mem[ex_mem.alu[AW-1:0]] : ex_mem.alu;
    wb_nxt.dst   = ex_mem.dst;
    wb_nxt.wr    = ex_mem.wr;
    wb_nxt.hlt   = ex_mem.hlt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PC           <= RESET_PC;
      halted       <= 1'b0;
      taken_branch <= 1'b0;
      if_id        <= '0;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
    end else begin
      taken_branch <= take;
      if (mem_wb.valid && mem_wb.hlt)
        halted <= 1'b1;
      if (take)
        PC <= target;
      else if (!ld_use && !hlt_pend)
        PC <= PC + 32'd1;
      if (take || (hlt_pend && !ld_use))
        if_id <= '0;
      else if (!ld_use)
        if_id <= '{valid: 1'b1, pc: PC, ir: Mem[PC[AW-1:0]]};
      if (take || ld_use || !if_id.valid)
        id_ex <= '0;
      else
        id_ex <= id_nxt;
      ex_mem <= ex_nxt;
      mem_wb <= wb_nxt;
    end
  end

  // architectural arrays survive reset; enables come from cleared valids
  always_ff @(posedge clock) begin
    if (wb_we)
      Reg[mem_wb.dst] <= mem_wb.res;
    if (ex_mem.valid && ex_mem.st && !halted)
      Mem[ex_mem.alu[AW-1:0]] <= ex_mem.b;
  end
endmodule

// File: tb/tb_mips.sv
// Directed bench for the mips core: programs are preloaded by hierarchy
// and architectural state is compared against hand-computed values.
module tb_mips;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic halted;

  int pass_n = 0;
  int total_n = 0;
  logic [31:0] prog [$];

  mips #(.MEM_DEPTH(1024), .RESET_PC(32'd0)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic setup();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
  endtask

  task automatic release_rst();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total_n++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    else
      pass_n++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total_n++;
    if (dut.PC !== 32'd0) $display("FAIL rst_pc: got %0h want 0", dut.PC);
    else pass_n++;
    total_n++;
    if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted);
    else pass_n++;
    total_n++;
    if (dut.taken_branch !== 1'b0)
      $display("FAIL rst_tb: got %b want 0", dut.taken_branch);
    else pass_n++;
  endtask

  task automatic load_fact();
    prog = '{32'h280a00c8, 32'h28020001, 32'h35430000, 32'h14e73800,
             32'h10431000, 32'h14e73800, 32'h2c630001, 32'h14e73800,
             32'h3c60fffb, 32'h3942fffe, 32'hfc000000};
    setup();
    dut.Mem[200] = 32'd7;
  endtask

  task automatic test_factorial();
    logic [31:0] seen [$];
    logic [31:0] expv [7];
    logic [31:0] last;
    bit ok;
    expv = '{32'd1, 32'd7, 32'd42, 32'd210, 32'd840, 32'd2520, 32'd5040};
    load_fact();
    last = dut.Reg[2];
    release_rst();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (dut.Reg[2] !== last) begin
        last = dut.Reg[2];
        seen.push_back(last);
      end
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fact_halted", {31'd0, ok}, 32'd1);
    chk("fact_mem198", dut.Mem[198], 32'd5040);
    chk("fact_mem200", dut.Mem[200], 32'd7);
    chk("fact_r2_changes", seen.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < seen.size()) chk($sformatf("fact_r2_%0d", i), seen[i], expv[i]);
  endtask

  task automatic test_forwarding();
    bit ok;
    prog = '{32'h280a00c8, 32'h28020001, 32'h35430000, 32'h10431000,
             32'h2c630001, 32'h3c60fffd, 32'h3942fffe, 32'hfc000000};
    setup();
    dut.Mem[200] = 32'd7;
    release_rst();
    run(300, ok);
    chk("fwd_halted", {31'd0, ok}, 32'd1);
    chk("fwd_mem198", dut.Mem[198], 32'd5040);
    chk("fwd_r3", dut.Reg[3], 32'd0);
  endtask

  task automatic test_load_use();
    bit ok;
    prog = '{32'h34010032, 32'h00212000, 32'hfc000000};
    setup();
    dut.Mem[50] = 32'd9;
    release_rst();
    run(100, ok);
    chk("lu_halted", {31'd0, ok}, 32'd1);
    chk("lu_r1", dut.Reg[1], 32'd9);
    chk("lu_r4", dut.Reg[4], 32'd18);
  endtask

  task automatic test_branch();
    bit ok;
    int pulses;
    prog = '{32'h40000002, 32'h28050001, 32'h28060001, 32'h28070001,
             32'hfc000000};
    setup();
    release_rst();
    ok = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dut.taken_branch) pulses++;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    chk("br_halted", {31'd0, ok}, 32'd1);
    chk("br_r5", dut.Reg[5], 32'd5);
    chk("br_r6", dut.Reg[6], 32'd6);
    chk("br_r7", dut.Reg[7], 32'd1);
    chk("br_pulses", pulses, 32'd1);
  endtask

  task automatic test_arith();
    bit ok;
    logic [31:0] pc0;
    prog = '{32'h28000005, 32'h00005000, 32'h2c010001, 32'h30220000,
             32'h28030100, 32'h10631800, 32'h10632000, 32'h0c204000,
             32'h04614800, 32'h1c0b0005, 32'hfc000000};
    setup();
    release_rst();
    run(100, ok);
    chk("ar_halted", {31'd0, ok}, 32'd1);
    chk("ar_r0", dut.Reg[0], 32'd0);
    chk("ar_r10", dut.Reg[10], 32'd0);
    chk("ar_r1", dut.Reg[1], 32'hffffffff);
    chk("ar_slti", dut.Reg[2], 32'd1);
    chk("ar_r3", dut.Reg[3], 32'h00010000);
    chk("ar_mul_wrap", dut.Reg[4], 32'd0);
    chk("ar_slt", dut.Reg[8], 32'd1);
    chk("ar_sub", dut.Reg[9], 32'd65537);
    chk("ar_nop_op", dut.Reg[11], 32'd11);
    pc0 = dut.PC;
    repeat (5) @(negedge clock);
    chk("ar_pc_frozen", dut.PC, pc0);
    chk("ar_halt_sticky", {31'd0, halted}, 32'd1);
  endtask

  task automatic test_reset_midrun();
    bit ok;
    load_fact();
    dut.Mem[198] = 32'd0;
    release_rst();
    repeat (25) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_pc", dut.PC, 32'd0);
    chk("mid_halted", {31'd0, halted}, 32'd0);
    chk("mid_no_store", dut.Mem[198], 32'd0);
    release_rst();
    run(300, ok);
    chk("mid_rerun_halted", {31'd0, ok}, 32'd1);
    chk("mid_rerun_mem198", dut.Mem[198], 32'd5040);
  endtask

  initial begin
    test_reset();
    test_factorial();
    test_forwarding();
    test_load_use();
    test_branch();
    test_arith();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
